// File: rtl/imem_loader_if.sv
// Loader-side bundle: start/size control, byte stream, memory write port and status.
// The loader uses the slave modport; the byte source/controller uses master.
interface imem_loader_if #(
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH) + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start;
  logic [CW-1:0] n_words;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;

  modport master (
    output start, n_words, s_data, s_valid,
    input  s_ready, we, wa, wd, busy, done, word_count
  );

  modport slave (
    input  start, n_words, s_data, s_valid,
    output s_ready, we, wa, wd, busy, done, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs little-endian stream bytes into 32-bit words and writes them
// to instruction memory; done doubles as the core run enable.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH) + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] target, word_count, n_clamped;
  logic [1:0]    idx;
  logic [31:0]   word;
  logic          busy_q, done_q;
  logic          s_ready_d, we_d;
  logic          start_ok, xfer, last_word;

  // Clamp keeps the final write address inside the memory.
  assign n_clamped = (bus.n_words > CW'(DEPTH)) ? CW'(DEPTH) : bus.n_words;
  assign start_ok  = bus.start && (state == IDLE || state == DONE);
  assign xfer      = bus.s_valid && s_ready_d;
  assign last_word = (word_count + CW'(1)) == target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = (n_clamped == '0) ? DONE : RECV;
      RECV:       if (bus.s_valid && idx == 2'd3) state_next = WRITE;
      WRITE:      state_next = last_word ? DONE : RECV;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready_d = (state == RECV);
    we_d      = (state == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target     <= '0;
      word_count <= '0;
      idx        <= '0;
      word       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        target     <= n_clamped;
        word_count <= '0;
        idx        <= '0;
      end else if (xfer) begin
        word[{idx, 3'b000} +: 8] <= bus.s_data;
        idx                      <= idx + 2'd1;
      end else if (state == WRITE) begin
        word_count <= word_count + CW'(1);
      end
      // Status flags track the upcoming state so they are registered yet aligned.
      busy_q <= (state_next == RECV) || (state_next == WRITE);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.s_ready    = s_ready_d;
  assign bus.we         = we_d;
  assign bus.wa         = AW'({word_count[CW-2:0], 2'b00});
  assign bus.wd         = word;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_count = word_count;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of single loads plus hand-written
// sequences for valid gaps, overlong loads, mid-load reset and restart.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH) + 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    int               n;
    logic [2:0][31:0] w;
    int               exp_wc;
    int               exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imem_loader_if #(.DEPTH(DEPTH)) bus ();
  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_rise = -1;
  int we_double = 0;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    bq[$];
  vec_t          vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port and done-edge monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.we) begin
      wa_q.push_back(bus.wa);
      wd_q.push_back(bus.wd);
      if (prev_we) we_double++;
    end
    prev_we = bus.we;
    if (bus.done && !prev_done) done_rise = cyc;
    prev_done = bus.done;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.s_ready, bus.we, bus.wa, bus.wd, bus.busy, bus.done, bus.word_count});
  endfunction

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    bq.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int unsigned b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.n_words = CW'(n);
    start_cyc   = cyc;
    done_rise   = -1;
  endtask

  // Offers bq byte by byte; advances only when s_valid && s_ready this cycle.
  task automatic send(input bit toggle, input int pulse_at, input int budget);
    int i = 0;
    int k = 0;
    while (i < bq.size() && k < budget) begin
      @(negedge clk);
      bus.start = (k == pulse_at);
      if (k == pulse_at) bus.n_words = CW'(5);
      bus.s_data  = bq[i];
      bus.s_valid = toggle ? (k % 2 == 0) : 1'b1;
      if (bus.s_valid && bus.s_ready) i++;
      k++;
    end
    if (i < bq.size()) check("send_timeout", 64'(i), 64'(bq.size()));
    @(negedge clk);
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) check("done_timeout", 64'(bus.done), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int lat;
    bus.start = 1'b0; bus.n_words = '0; bus.s_data = '0; bus.s_valid = 1'b0;

    vecs[0] = '{n: 0, w: '0, exp_wc: 0, exp_lat: 1};
    vecs[1] = '{n: 2, w: {32'h0, 32'h001000B3, 32'h00000013}, exp_wc: 2, exp_lat: 11};
    vecs[2] = '{n: 1, w: {32'h0, 32'h0, 32'hDEADBEEF}, exp_wc: 1, exp_lat: 6};
    vecs[3] = '{n: 0, w: '0, exp_wc: 0, exp_lat: -1};
    vecs[4] = '{n: 3, w: {32'h00000001, 32'hA5A5A5A5, 32'h12345678}, exp_wc: 3, exp_lat: 16};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs(), 64'(0));

    foreach (vecs[r]) begin
      clear_q();
      for (int unsigned i = 0; i < 32'(vecs[r].n); i++) push_word(vecs[r].w[i]);
      do_start(vecs[r].n);
      send(1'b0, -1, vecs[r].n * 8 + 20);
      wait_done(40);
      repeat (2) @(negedge clk);
      check($sformatf("row%0d_writes", r), 64'(wa_q.size()), 64'(vecs[r].n));
      for (int i = 0; i < vecs[r].n && i < wa_q.size(); i++) begin
        check($sformatf("row%0d_wa%0d", r, i), 64'(wa_q[i]), 64'(i * 4));
        check($sformatf("row%0d_wd%0d", r, i), 64'(wd_q[i]), 64'(vecs[r].w[i]));
      end
      check($sformatf("row%0d_word_count", r), 64'(bus.word_count), 64'(vecs[r].exp_wc));
      check($sformatf("row%0d_done", r), 64'({bus.done, bus.busy, bus.s_ready}), 64'(3'b100));
      lat = (done_rise < 0) ? -1 : done_rise - start_cyc;
      check($sformatf("row%0d_latency", r), 64'(lat), 64'(vecs[r].exp_lat));
    end

    // Same two-word program with s_valid low on alternate cycles.
    clear_q();
    push_word(32'h00000013);
    push_word(32'h001000B3);
    do_start(2);
    send(1'b1, -1, 60);
    wait_done(40);
    @(negedge clk);
    check("toggle_writes", 64'(wa_q.size()), 64'(2));
    if (wa_q.size() == 2) begin
      check("toggle_wa1", 64'(wa_q[1]), 64'(4));
      check("toggle_wd0", 64'(wd_q[0]), 64'(32'h00000013));
      check("toggle_wd1", 64'(wd_q[1]), 64'(32'h001000B3));
    end
    check("toggle_word_count", 64'(bus.word_count), 64'(2));

    // Request larger than the memory: clamped to DEPTH words.
    clear_q();
    for (int unsigned i = 0; i < DEPTH; i++) push_word(32'hC0DE0000 | i);
    do_start(DEPTH + 5);
    send(1'b0, -1, DEPTH * 4 * 2 + 100);
    wait_done(40);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hEE;
      check("clamp_ready_low", 64'(bus.s_ready), 64'(0));
    end
    bus.s_valid = 1'b0;
    check("clamp_writes", 64'(wa_q.size()), 64'(DEPTH));
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== AW'(i * 4) || wd_q[i] !== (32'hC0DE0000 | 32'(i))) bad++;
    check("clamp_bad_writes", 64'(bad), 64'(0));
    if (wa_q.size() > 0) check("clamp_last_wa", 64'(wa_q[wa_q.size()-1]), 64'(12'h3FC));
    check("clamp_word_count", 64'(bus.word_count), 64'(DEPTH));
    check("clamp_done", 64'(bus.done), 64'(1));

    // Reset after six bytes of a four-word load.
    clear_q();
    push_word(32'h04030201);
    push_word(32'h08070605);
    void'(bq.pop_back());
    void'(bq.pop_back());
    do_start(4);
    send(1'b0, -1, 40);
    check("pre_reset_state", 64'({bus.busy, bus.word_count}), 64'({1'b1, CW'(1)}));
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", outs(), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    push_word(32'h44332211);
    do_start(1);
    send(1'b0, -1, 20);
    wait_done(40);
    @(negedge clk);
    check("post_reset_writes", 64'(wa_q.size()), 64'(1));
    if (wa_q.size() == 1) begin
      check("post_reset_wa", 64'(wa_q[0]), 64'(0));
      check("post_reset_wd", 64'(wd_q[0]), 64'(32'h44332211));
    end

    // start pulsed mid-load is ignored, then a restart after done.
    clear_q();
    push_word(32'hCAFEF00D);
    push_word(32'h0BADC0DE);
    do_start(2);
    send(1'b0, 3, 40);
    wait_done(40);
    @(negedge clk);
    check("midstart_writes", 64'(wa_q.size()), 64'(2));
    if (wd_q.size() == 2) check("midstart_wd1", 64'(wd_q[1]), 64'(32'h0BADC0DE));
    check("midstart_word_count", 64'(bus.word_count), 64'(2));
    clear_q();
    push_word(32'h00500093);
    do_start(1);
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_done_drops", 64'({bus.done, bus.busy, bus.word_count}), 64'({2'b01, CW'(0)}));
    send(1'b0, -1, 20);
    wait_done(40);
    @(negedge clk);
    check("restart_writes", 64'(wa_q.size()), 64'(1));
    if (wa_q.size() == 1) begin
      check("restart_wa", 64'(wa_q[0]), 64'(0));
      check("restart_wd", 64'(wd_q[0]), 64'(32'h00500093));
    end
    check("restart_done", 64'(bus.done), 64'(1));
    check("we_single_cycle", 64'(we_double), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
